// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle instruction sequencer.
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Instruction decode is external and combinational on ir_out. Branch
// redirects are captured in EXEC and applied to the PC in WB. The sequencer
// parks in FAULT on an illegal decode or a misaligned target; only reset
// leaves FAULT. Request and strobe outputs are decoded from the registered
// state and forced low while reset is high, so an access that is in flight
// when reset arrives is abandoned cleanly.
module mc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0040_0000),
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           ir_out,
  input  logic                  dec_mem_rd,
  input  logic                  dec_mem_wr,
  input  logic                  dec_reg_wr,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  regfile_we,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus_step,
  output logic                  retired,
  output logic [31:0]           instr_count,
  output logic [2:0]            state_out,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           ir_q;
  logic [31:0]           instr_count_q;
  logic                  redir_en_q;
  logic [ADDR_WIDTH-1:0] redir_pc_q;
  logic                  fault_q;

  // Sequential successor and the PC that WB will commit.
  logic [ADDR_WIDTH-1:0] pc_step_d;
  logic [ADDR_WIDTH-1:0] pc_d;

  // A redirect target must be word aligned; anything else is fatal.
  logic misaligned_redirect;
  logic illegal_decode;

  assign pc_step_d           = pc_q + ADDR_WIDTH'(PC_STEP);
  assign pc_d                = redir_en_q ? redir_pc_q : pc_step_d;
  assign misaligned_redirect = redirect_en && (redirect_pc[1:0] != 2'b00);
  assign illegal_decode      = dec_mem_rd && dec_mem_wr;

  // Main FSM: state, PC, instruction register, counter and redirect latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      instr_count_q <= '0;
      redir_en_q    <= 1'b0;
      redir_pc_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          redir_en_q <= redirect_en;
          redir_pc_q <= redirect_pc;
          // Alignment is checked ahead of the memory routing decision.
          if (misaligned_redirect || illegal_decode) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else if (dec_mem_rd || dec_mem_wr) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_q <= S_WB;
          end
        end
        S_WB: begin
          pc_q          <= pc_d;
          instr_count_q <= instr_count_q + 32'd1;
          redir_en_q    <= 1'b0;
          state_q       <= S_FETCH;
        end
        S_FAULT: begin
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // Request/strobe decode from state; reset overrides whatever state is held.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regfile_we = 1'b0;
    retired    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_mem_wr;
        end
        S_WB: begin
          regfile_we = dec_reg_wr;
          retired    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign pc_out       = pc_q;
  assign pc_plus_step = pc_step_d;
  assign ir_out       = ir_q;
  assign instr_count  = instr_count_q;
  assign state_out    = state_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer. Expected per-instruction outcomes are
// pushed to a scoreboard queue when each instruction is issued and popped
// when the sequencer returns to FETCH (or faults).
`timescale 1ns/1ps
module tb_mc_sequencer;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic        dec_mem_rd, dec_mem_wr, dec_reg_wr;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        regfile_we;
  logic [31:0] pc_out, pc_plus_step;
  logic        retired;
  logic [31:0] instr_count;
  logic [2:0]  state_out;
  logic        fault;

  mc_sequencer dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_out(ir_out),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .regfile_we(regfile_we), .pc_out(pc_out), .pc_plus_step(pc_plus_step),
    .retired(retired), .instr_count(instr_count), .state_out(state_out), .fault(fault)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd, wr, rw, ren;
    logic [31:0] rpc;
    int          iw, dw;
    logic        noise, decred;
  } instr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    int          cycles;
    int          wb_cyc;
    int          rf;
    int          ret;
    int          dreq;
    int          dec_busy;
    logic        we;
    logic        faulted;
    logic        timeout;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_count;

  task automatic clear_inputs();
    imem_ack = 0; imem_rdata = 0; dmem_ack = 0;
    dec_mem_rd = 0; dec_mem_wr = 0; dec_reg_wr = 0;
    redirect_en = 0; redirect_pc = 0;
  endtask

  // Holds reset for n cycles; returns on a falling edge with reset released.
  task automatic do_reset(input int n);
    clear_inputs();
    reset = 1;
    repeat (n) @(negedge clock);
    reset = 0;
    model_pc = RPC;
    model_count = 0;
  endtask

  // Drives one instruction from FETCH until the next FETCH (or FAULT).
  // Entered and left on a falling edge.
  task automatic drive_instr(input instr_t in, input logic [31:0] word, output rec_t obs);
    int iw, dw;
    logic seen_wb;
    logic [2:0] st;
    obs.addr = 0; obs.ir = 0; obs.cycles = 0; obs.wb_cyc = 0; obs.rf = 0;
    obs.ret = 0; obs.dreq = 0; obs.dec_busy = 0; obs.we = 0;
    obs.faulted = 0; obs.timeout = 0;
    iw = in.iw; dw = in.dw; seen_wb = 0;
    for (int c = 0; c < 100; c++) begin
      st = state_out;
      if (seen_wb && st == 3'd0) return;
      if (st == 3'd7) begin
        obs.faulted = 1;
        return;
      end
      imem_ack    = in.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata  = $urandom;
      dmem_ack    = in.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      redirect_en = in.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      redirect_pc = $urandom;
      dec_mem_rd = 0; dec_mem_wr = 0; dec_reg_wr = 0;
      if (st != 3'd0) begin
        dec_mem_rd = in.rd; dec_mem_wr = in.wr; dec_reg_wr = in.rw;
      end
      case (st)
        3'd0: begin
          imem_rdata = word;
          if (iw > 0) begin imem_ack = 0; iw--; end
          else imem_ack = 1;
        end
        3'd1: if (in.decred) begin redirect_en = 1; redirect_pc = 32'h0040_0100; end
        3'd2: begin redirect_en = in.ren; redirect_pc = in.rpc; end
        3'd3: begin
          if (dw > 0) begin dmem_ack = 0; dw--; end
          else dmem_ack = 1;
        end
        3'd4: seen_wb = 1;
        default: ;
      endcase
      #1;
      obs.cycles++;
      if (st == 3'd0 && imem_ack) obs.addr = imem_addr;
      if (st == 3'd1) begin
        obs.ir = ir_out;
        if (imem_req || dmem_req || regfile_we || retired) obs.dec_busy++;
      end
      if (dmem_req) obs.dreq++;
      if (dmem_req && dmem_we) obs.we = 1;
      if (regfile_we) begin obs.rf++; obs.wb_cyc = obs.cycles; end
      if (retired) obs.ret++;
      @(negedge clock);
    end
    obs.timeout = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if ({imem_req, dmem_req, dmem_we, regfile_we, retired} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {imem_req, dmem_req, dmem_we, regfile_we, retired});
    end
    @(negedge clock);
    reset = 0;
    model_pc = RPC; model_count = 0;
    #1;
    checks++;
    if (pc_out !== RPC || ir_out !== 32'h0 || instr_count !== 32'h0 || fault !== 1'b0 || state_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ir=%h cnt=%0d fault=%b st=%0d expected pc=%h ir=0 cnt=0 fault=0 st=0",
               pc_out, ir_out, instr_count, fault, state_out, RPC);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      errors++;
      $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    @(negedge clock);
    reset = 1; // state held in FETCH; restart cleanly for the program test
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_program();
    instr_t prog[$];
    instr_t in;
    rec_t exp, got;
    logic [31:0] word;
    logic mem;
    // ALU, delayed load, store, branch, decode-only redirect, stray inputs
    prog.push_back('{0, 0, 1, 0, 32'h0, 0, 0, 0, 0});
    prog.push_back('{1, 0, 1, 0, 32'h0, 0, 3, 0, 0});
    prog.push_back('{0, 1, 0, 0, 32'h0, 0, 0, 0, 0});
    prog.push_back('{0, 0, 0, 1, 32'h0040_0100, 0, 0, 0, 0});
    prog.push_back('{0, 0, 1, 0, 32'h0, 0, 0, 0, 1});
    prog.push_back('{0, 0, 1, 0, 32'h0, 2, 0, 1, 0});
    prog.push_back('{1, 0, 1, 1, 32'h0040_0200, 1, 2, 1, 0});
    prog.push_back('{0, 1, 1, 0, 32'h0, 0, 1, 1, 0});
    // back-to-back random legal instructions
    for (int k = 0; k < 12; k++) begin
      in.rd = 1'($urandom_range(0, 1));
      in.wr = in.rd ? 1'b0 : 1'($urandom_range(0, 1));
      in.rw = 1'($urandom_range(0, 1));
      in.ren = 1'($urandom_range(0, 1));
      in.rpc = RPC + ($urandom_range(0, 255) << 2);
      in.iw = $urandom_range(0, 2);
      in.dw = $urandom_range(0, 2);
      in.noise = 1'($urandom_range(0, 1));
      in.decred = 0;
      prog.push_back(in);
    end
    foreach (prog[i]) begin
      in = prog[i];
      word = $urandom;
      mem = in.rd | in.wr;
      exp.addr = model_pc;
      exp.ir = word;
      exp.cycles = 4 + in.iw + (mem ? in.dw + 1 : 0);
      exp.wb_cyc = in.rw ? exp.cycles : 0;
      exp.rf = in.rw ? 1 : 0;
      exp.ret = 1;
      exp.dreq = mem ? in.dw + 1 : 0;
      exp.dec_busy = 0;
      exp.we = in.wr;
      exp.faulted = 0;
      exp.timeout = 0;
      exp_q.push_back(exp);
      model_pc = in.ren ? in.rpc : model_pc + 32'd4;
      model_count = model_count + 32'd1;
      drive_instr(in, word, got);
      exp = exp_q.pop_front();
      checks++;
      if (got.timeout !== exp.timeout || got.faulted !== exp.faulted) begin
        errors++;
        $display("FAIL prog[%0d] completion: got timeout=%b fault=%b expected 0/0", i, got.timeout, got.faulted);
      end
      checks++;
      if (got.addr !== exp.addr) begin
        errors++;
        $display("FAIL prog[%0d] fetch_addr: got %h expected %h", i, got.addr, exp.addr);
      end
      checks++;
      if (got.ir !== exp.ir) begin
        errors++;
        $display("FAIL prog[%0d] ir_out: got %h expected %h", i, got.ir, exp.ir);
      end
      checks++;
      if (got.cycles !== exp.cycles || got.wb_cyc !== exp.wb_cyc) begin
        errors++;
        $display("FAIL prog[%0d] latency: got cycles=%0d wb=%0d expected cycles=%0d wb=%0d",
                 i, got.cycles, got.wb_cyc, exp.cycles, exp.wb_cyc);
      end
      checks++;
      if (got.rf !== exp.rf || got.ret !== exp.ret || got.dec_busy !== exp.dec_busy) begin
        errors++;
        $display("FAIL prog[%0d] strobes: got rf=%0d ret=%0d dec=%0d expected rf=%0d ret=%0d dec=0",
                 i, got.rf, got.ret, got.dec_busy, exp.rf, exp.ret);
      end
      checks++;
      if (got.dreq !== exp.dreq || got.we !== exp.we) begin
        errors++;
        $display("FAIL prog[%0d] dmem: got req_cycles=%0d we=%b expected req_cycles=%0d we=%b",
                 i, got.dreq, got.we, exp.dreq, exp.we);
      end
      checks++;
      if (pc_out !== model_pc || imem_addr !== model_pc || pc_plus_step !== model_pc + 32'd4 || instr_count !== model_count) begin
        errors++;
        $display("FAIL prog[%0d] next_pc: got pc=%h addr=%h pps=%h cnt=%0d expected pc=%h cnt=%0d",
                 i, pc_out, imem_addr, pc_plus_step, instr_count, model_pc, model_count);
      end
    end
  endtask

  task automatic test_fault();
    instr_t in;
    rec_t got;
    logic [31:0] word;
    int bad;
    for (int f = 0; f < 2; f++) begin
      in = '{0, 0, 1, 1, 32'h0040_0102, 0, 0, 0, 0};
      if (f == 1) in = '{1, 1, 1, 0, 32'h0, 0, 0, 0, 0};
      word = $urandom;
      drive_instr(in, word, got);
      checks++;
      if (got.faulted !== 1'b1 || got.ret !== 0 || state_out !== 3'd7 || fault !== 1'b1) begin
        errors++;
        $display("FAIL fault[%0d] entry: got faulted=%b ret=%0d st=%0d fault=%b expected 1/0/7/1",
                 f, got.faulted, got.ret, state_out, fault);
      end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
        redirect_en = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        dec_reg_wr = 1; dec_mem_wr = 1; dec_mem_rd = 0;
        #1;
        if (imem_req || dmem_req || dmem_we || regfile_we || retired || state_out !== 3'd7 ||
            fault !== 1'b1 || pc_out !== model_pc || ir_out !== word) bad++;
        @(negedge clock);
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL fault[%0d] frozen: got %0d bad cycles expected 0", f, bad);
      end
      do_reset(1);
      #1;
      checks++;
      if (fault !== 1'b0 || state_out !== 3'd0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
        errors++;
        $display("FAIL fault[%0d] recover: got fault=%b st=%0d req=%b addr=%h expected 0/0/1/%h",
                 f, fault, state_out, imem_req, imem_addr, RPC);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    instr_t in;
    rec_t got;
    // abandon a read in MEM with a coincident ack
    do_reset(1);
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    @(negedge clock);
    imem_ack = 0; dec_mem_rd = 1; dec_reg_wr = 1;
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (state_out !== 3'd3 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem setup: got st=%0d dreq=%b expected 3/1", state_out, dmem_req);
    end
    dmem_ack = 1; reset = 1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || regfile_we !== 1'b0 || retired !== 1'b0) begin
      errors++;
      $display("FAIL mid_mem strobes: got dreq=%b rfwe=%b ret=%b expected 0/0/0", dmem_req, regfile_we, retired);
    end
    @(negedge clock);
    reset = 0; clear_inputs();
    #1;
    checks++;
    if (instr_count !== 32'h0 || state_out !== 3'd0 || imem_addr !== RPC || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem restart: got cnt=%0d st=%0d addr=%h req=%b expected 0/0/%h/1",
               instr_count, state_out, imem_addr, imem_req, RPC);
    end
    @(negedge clock);
    // abandon a fetch with a coincident ack
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; reset = 1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_fetch req: got %b expected 0", imem_req);
    end
    @(negedge clock);
    reset = 0; clear_inputs();
    model_pc = RPC; model_count = 0;
    #1;
    checks++;
    if (ir_out !== 32'h0 || state_out !== 3'd0) begin
      errors++;
      $display("FAIL mid_fetch ir: got ir=%h st=%0d expected 0/0", ir_out, state_out);
    end
    in = '{0, 0, 1, 0, 32'h0, 0, 0, 0, 0};
    drive_instr(in, 32'h0000_0013, got);
    checks++;
    if (got.addr !== RPC || instr_count !== 32'd1 || got.ret !== 1) begin
      errors++;
      $display("FAIL mid_fetch rerun: got addr=%h cnt=%0d ret=%0d expected %h/1/1", got.addr, instr_count, got.ret, RPC);
    end
    model_pc = RPC + 32'd4; model_count = 1;
  endtask

  task automatic test_count_wrap();
    instr_t in;
    rec_t got;
    logic [31:0] want;
    in = '{0, 0, 1, 0, 32'h0, 0, 0, 0, 0};
    force dut.instr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.instr_count_q;
    model_count = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      drive_instr(in, $urandom, got);
      model_count = model_count + 32'd1;
      want = model_count;
      checks++;
      if (instr_count !== want || got.ret !== 1) begin
        errors++;
        $display("FAIL count_wrap[%0d]: got cnt=%h ret=%0d expected cnt=%h ret=1", k, instr_count, got.ret, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_fault();
    test_reset_mid_access();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
